// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and defaults for the main-memory arbiter and the cache controllers that talk to it.
// The optional protocol checker is enabled with the MEM_ARB_ERR_EN macro in the arbiter files.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned MEM_LAT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_I    = 2'd1,
    OWNER_D    = 2'd2
  } owner_t;

  // Counter width able to hold 0..max_cnt inclusive
  function automatic int unsigned cnt_width(input int unsigned max_cnt);
    return $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/mem_arb_outcnt.sv
// Saturating up/down count of memory reads still in flight.
// Empty/full flags are only exported when MEM_ARB_ERR_EN is defined.
module mem_arb_outcnt
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX = MEM_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic zero_nxt_c
`ifdef MEM_ARB_ERR_EN
  ,
  output logic empty_c,
  output logic full_c
`endif
);

  localparam int unsigned CW = cnt_width(MAX);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          sat_hi;
  logic          sat_lo;

  assign sat_hi = (cnt == CW'(MAX));
  assign sat_lo = (cnt == '0);

  // Simultaneous issue and return leave the count unchanged
  always_comb begin
    cnt_nxt = cnt;
    if (inc && !dec && !sat_hi) begin
      cnt_nxt = cnt + CW'(1);
    end else if (dec && !inc && !sat_lo) begin
      cnt_nxt = cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  assign zero_nxt_c = (cnt_nxt == '0);

`ifdef MEM_ARB_ERR_EN
  assign empty_c = sat_lo;
  assign full_c  = sat_hi;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin owner of main memory shared by the I-cache fill and D-cache fill/write-through paths.
// Define MEM_ARB_ERR_EN to build the sticky protocol-error detector behind err.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_data_valid,
  input  logic              d_req,
  input  logic              d_en,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_data_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_data_valid,
  output logic              err
);

  arb_state_t state, state_nxt;
  owner_t     owner, owner_nxt;
  owner_t     last, last_nxt;
  logic       rd_issue;
  logic       cnt_zero_nxt;

  // Grants follow the registered state; the owner's beat passes straight through
  assign i_gnt      = (state == OWN_I);
  assign d_gnt      = (state == OWN_D);
  assign mem_enable = (i_gnt & i_en) | (d_gnt & d_en);
  assign mem_wr     = d_gnt & d_en & d_wr;
  assign mem_addr   = i_gnt ? i_addr : (d_gnt ? d_addr : '0);
  assign mem_wdata  = d_gnt ? d_wdata : '0;
  assign rd_issue   = mem_enable & ~mem_wr;

  // Returns go to the recorded owner; with no owner they are dropped
  assign i_data_valid = mem_data_valid & (owner == OWNER_I);
  assign d_data_valid = mem_data_valid & (owner == OWNER_D);
  assign rdata        = (i_data_valid | d_data_valid) ? mem_rdata : '0;

`ifdef MEM_ARB_ERR_EN
  logic cnt_empty;
  logic cnt_full;
`endif

  mem_arb_outcnt #(
    .MAX (MEM_LAT)
  ) u_outcnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (rd_issue),
    .dec        (mem_data_valid),
    .zero_nxt_c (cnt_zero_nxt)
`ifdef MEM_ARB_ERR_EN
    ,
    .empty_c    (cnt_empty),
    .full_c     (cnt_full)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= OWNER_NONE;
      last  <= OWNER_I;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

  // Arbitration and release; a tie goes to the side that was not granted last
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (d_req && (!i_req || (last == OWNER_I))) begin
          state_nxt = OWN_D;
          owner_nxt = OWNER_D;
          last_nxt  = OWNER_D;
        end else if (i_req) begin
          state_nxt = OWN_I;
          owner_nxt = OWNER_I;
          last_nxt  = OWNER_I;
        end
      end
      OWN_I: begin
        if (!i_req) begin
          state_nxt = cnt_zero_nxt ? IDLE : DRAIN;
          if (cnt_zero_nxt) owner_nxt = OWNER_NONE;
        end
      end
      OWN_D: begin
        if (!d_req) begin
          state_nxt = cnt_zero_nxt ? IDLE : DRAIN;
          if (cnt_zero_nxt) owner_nxt = OWNER_NONE;
        end
      end
      DRAIN: begin
        if (cnt_zero_nxt) begin
          state_nxt = IDLE;
          owner_nxt = OWNER_NONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        owner_nxt = OWNER_NONE;
      end
    endcase
  end

`ifdef MEM_ARB_ERR_EN
  logic err_q;
  logic err_set;

  assign err_set = (i_en & ~i_gnt) | (d_en & ~d_gnt) |
                   (mem_data_valid & cnt_empty) | (rd_issue & cnt_full) |
                   (mem_wr & ~d_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random two-requester traffic
// against a transaction-level ownership model and a fixed-latency memory stub.
module tb_mem_arbiter;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_en, i_gnt, i_data_valid;
  logic [15:0] i_addr;
  logic        d_req, d_en, d_wr, d_gnt, d_data_valid;
  logic [15:0] d_addr, d_wdata;
  logic [15:0] rdata;
  logic        mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_data_valid;
  logic        err;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .MEM_LAT (L)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req          (i_req),
    .i_en           (i_en),
    .i_addr         (i_addr),
    .i_gnt          (i_gnt),
    .i_data_valid   (i_data_valid),
    .d_req          (d_req),
    .d_en           (d_en),
    .d_wr           (d_wr),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_gnt          (d_gnt),
    .d_data_valid   (d_data_valid),
    .rdata          (rdata),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_data_valid (mem_data_valid),
    .err            (err)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    logic [15:0] addr;
  } rd_t;
  rd_t memq[$];

  // Model: who holds the grant, who receives returns, last winner (1=I, 2=D), reads in flight
  int m_gnt, m_route, m_last, m_cnt;
  bit m_err;

  logic        s_i_gnt, s_d_gnt, s_i_dv, s_d_dv, s_men, s_mwr, s_err;
  logic [15:0] s_maddr, s_mwdata, s_rdata;
  int          n_idv, n_ddv, first_idv;
  logic [15:0] first_rdata;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_gnt = 0; m_route = 0; m_last = 1; m_cnt = 0; m_err = 1'b0;
  endtask

  task automatic clr_counts();
    n_idv = 0; n_ddv = 0; first_idv = -1; first_rdata = 16'h0;
  endtask

  // One clock: memory response, mid-cycle compare, model advance, land at posedge+1
  task automatic tick();
    logic        e_men, e_mwr, e_idv, e_ddv, hreq;
    logic [15:0] e_addr, e_wdata, e_rdata;
    bit          rd;
    int          nc, win;
    if (memq.size() > 0 && memq[0].due == cyc) begin
      mem_data_valid = 1'b1;
      mem_rdata      = mem_val(memq[0].addr);
    end else begin
      mem_data_valid = 1'b0;
      mem_rdata      = 16'($urandom);
    end
    @(negedge clk);
    if (!rst_n) model_reset();
    e_men   = (m_gnt == 1 && i_en) || (m_gnt == 2 && d_en);
    e_mwr   = (m_gnt == 2) && d_en && d_wr;
    e_addr  = (m_gnt == 1) ? i_addr : ((m_gnt == 2) ? d_addr : 16'h0);
    e_wdata = (m_gnt == 2) ? d_wdata : 16'h0;
    e_idv   = mem_data_valid && (m_route == 1);
    e_ddv   = mem_data_valid && (m_route == 2);
    e_rdata = (e_idv || e_ddv) ? mem_rdata : 16'h0;
    s_i_gnt = i_gnt; s_d_gnt = d_gnt; s_i_dv = i_data_valid; s_d_dv = d_data_valid;
    s_men = mem_enable; s_mwr = mem_wr; s_maddr = mem_addr; s_mwdata = mem_wdata;
    s_rdata = rdata; s_err = err;
    chk("i_gnt", s_i_gnt, (m_gnt == 1));
    chk("d_gnt", s_d_gnt, (m_gnt == 2));
    chk("mem_enable", s_men, e_men);
    chk("mem_wr", s_mwr, e_mwr);
    chk("mem_addr", s_maddr, e_addr);
    chk("mem_wdata", s_mwdata, e_wdata);
    chk("i_data_valid", s_i_dv, e_idv);
    chk("d_data_valid", s_d_dv, e_ddv);
    chk("rdata", s_rdata, e_rdata);
    chk("err", s_err, m_err);
    if (s_i_dv === 1'b1) begin
      if (first_idv < 0) begin first_idv = cyc; first_rdata = s_rdata; end
      n_idv++;
    end
    if (s_d_dv === 1'b1) n_ddv++;
    if (mem_data_valid) void'(memq.pop_front());
    if (mem_enable === 1'b1 && mem_wr === 1'b0) memq.push_back('{cyc + L, mem_addr});
    if (rst_n) begin
      rd = e_men && !e_mwr;
`ifdef MEM_ARB_ERR_EN
      if ((i_en && m_gnt != 1) || (d_en && m_gnt != 2) || (mem_data_valid && m_cnt == 0) ||
          (rd && m_cnt == L) || (e_mwr && !d_req)) m_err = 1'b1;
`endif
      nc = m_cnt;
      if (rd && !mem_data_valid) nc = (m_cnt < L) ? m_cnt + 1 : L;
      else if (mem_data_valid && !rd) nc = (m_cnt > 0) ? m_cnt - 1 : 0;
      hreq = (m_gnt == 1) ? i_req : d_req;
      if (m_gnt != 0) begin
        if (!hreq) begin
          m_gnt = 0;
          if (nc == 0) m_route = 0;
        end
      end else if (m_route != 0) begin
        if (nc == 0) m_route = 0;
      end else if (i_req || d_req) begin
        win = (i_req && d_req) ? ((m_last == 1) ? 2 : 1) : (d_req ? 2 : 1);
        m_gnt = win; m_route = win; m_last = win;
      end
      m_cnt = nc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int w, i_beats, d_beats;
    rst_n = 1'b0;
    i_req = 1'b1; i_en = 1'b1; i_addr = 16'h1111;
    d_req = 1'b1; d_en = 1'b1; d_wr = 1'b1; d_addr = 16'h2222; d_wdata = 16'h3333;
    mem_data_valid = 1'b1; mem_rdata = 16'h4444;
    model_reset();
    clr_counts();
    #1;
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_mem_enable", mem_enable, 0);
    chk("rst_i_dv", i_data_valid, 0);
    chk("rst_rdata", rdata, 0);
    i_req = 0; i_en = 0; d_req = 0; d_en = 0; d_wr = 0; mem_data_valid = 0;
    @(posedge clk);
    #1;
    tick();
    rst_n = 1'b1;
    tick();

    // I fill of 8 beats
    clr_counts();
    i_req = 1;
    tick();
    chk("ifill_gnt_wait", s_i_gnt, 0);
    w = cyc;
    for (int k = 0; k < 8; k++) begin
      i_en = 1; i_addr = 16'h1230 + 16'(2 * k);
      tick();
      if (k == 0) chk("ifill_gnt", s_i_gnt, 1);
    end
    i_en = 0;
    repeat (4) tick();
    i_req = 0;
    tick(); tick();
    chk("ifill_i_pulses", n_idv, 8);
    chk("ifill_d_pulses", n_ddv, 0);
    chk("ifill_latency", first_idv - w, 4);
    chk("ifill_rdata0", first_rdata, 16'h486A);

    // Tie from reset goes to D, then drain with three reads in flight
    rst_n = 0;
    tick();
    rst_n = 1;
    clr_counts();
    i_req = 1; d_req = 1;
    tick();
    chk("tie_gnt_wait", s_d_gnt, 0);
    d_en = 1; d_addr = 16'h0100;
    tick();
    chk("tie_d_gnt", s_d_gnt, 1);
    chk("tie_i_gnt", s_i_gnt, 0);
    d_addr = 16'h0102; tick();
    d_addr = 16'h0104; tick();
    d_en = 0; d_req = 0;
    tick();
    w = 0;
    do begin
      tick();
      w++;
      if (w == 1) chk("drain_gnt_drop", s_d_gnt, 0);
    end while (s_i_gnt !== 1'b1 && w < 20);
    chk("drain_to_i_gnt", w, 5);
    chk("drain_d_pulses", n_ddv, 3);
    chk("drain_i_pulses", n_idv, 0);
    i_req = 0;
    tick();
    i_req = 1; d_req = 1;
    tick();
    tick();
    chk("rr_d_gnt", s_d_gnt, 1);
    chk("rr_i_gnt", s_i_gnt, 0);

    // Single write by D, release straight to IDLE
    i_req = 0;
    d_en = 1; d_wr = 1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
    tick();
    chk("wr_mem_enable", s_men, 1);
    chk("wr_mem_wr", s_mwr, 1);
    chk("wr_mem_addr", s_maddr, 16'h0040);
    chk("wr_mem_wdata", s_mwdata, 16'hBEEF);
    d_en = 0; d_wr = 0; d_req = 0; i_req = 1;
    tick();
    tick();
    chk("wr_release_idle", s_d_gnt, 0);
    tick();
    chk("wr_then_i_gnt", s_i_gnt, 1);
    i_req = 0;
    tick(); tick();

    // Reset while D has two reads in flight; late returns are dropped
    d_req = 1;
    tick();
    d_en = 1; d_addr = 16'h0200; tick();
    d_addr = 16'h0202; tick();
    clr_counts();
    rst_n = 0;
    #1;
    chk("midrst_d_gnt", d_gnt, 0);
    chk("midrst_mem_enable", mem_enable, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_err", err, 0);
    tick(); tick();
    rst_n = 1; d_req = 0; d_en = 0;
    tick(); tick(); tick();
    chk("midrst_late_drop", n_ddv, 0);

    // Random two-requester traffic with occasional resets
    i_beats = 0; d_beats = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 0; i_req = 0; i_en = 0; d_req = 0; d_en = 0;
        tick();
        rst_n = 1;
        continue;
      end
      i_en = 0;
      if (!i_req) begin
        if ($urandom_range(0, 5) == 0) begin i_req = 1; i_beats = $urandom_range(1, 8); end
      end else if (i_gnt) begin
        if (i_beats == 0) i_req = 0;
        else if ($urandom_range(0, 3) != 0) begin
          i_en = 1; i_addr = 16'($urandom); i_beats--;
        end
      end
      d_en = 0;
      d_wr = 1'($urandom_range(0, 2) == 0);
      d_wdata = 16'($urandom);
      if (!d_req) begin
        if ($urandom_range(0, 5) == 0) begin d_req = 1; d_beats = $urandom_range(1, 6); end
      end else if (d_gnt) begin
        if (d_beats == 0) d_req = 0;
        else if ($urandom_range(0, 3) != 0) begin
          d_en = 1; d_addr = 16'($urandom); d_beats--;
        end
      end
      tick();
    end

    // Enable without grant is blocked; err reacts only in the checker build
    i_req = 0; i_en = 0; d_req = 0; d_en = 0; d_wr = 0;
    repeat (10) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
    chk("err_clear", s_err, 0);
    i_en = 1;
    tick();
    chk("ungranted_en_blocked", s_men, 0);
    i_en = 0;
    tick();
`ifdef MEM_ARB_ERR_EN
    chk("err_set", s_err, 1);
    tick();
    chk("err_sticky", s_err, 1);
`else
    chk("err_tied_low", s_err, 0);
    tick();
    chk("err_still_low", s_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
